// File: rtl/alu_seq_mul.sv
// Multi-cycle ALU: registered ADD/SUB/AND/OR/XOR in one cycle, unsigned
// shift-add MUL in WIDTH+1 cycles, with a start/busy/done handshake.
module alu_seq_mul #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             carry,
   output logic             overflow,
   output logic             err,
   output logic             busy,
   output logic             done
);

   // EXEC is the one-cycle stage between accept and DONE for non-MUL ops;
   // start is not accepted there, matching the "accept only in IDLE/DONE" rule.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] MUL  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;

   logic [1:0]         state;
   logic [2:0]         op_q;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   opa;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_lo;
   logic               alu_c;
   logic               alu_v;
   logic               alu_err;

   // Latched operands live in the multiplier registers for every op.
   assign opa  = mcand[WIDTH-1:0];
   assign sum  = {1'b0, opa} + {1'b0, mplier};
   assign diff = {1'b0, opa} - {1'b0, mplier};

   always_comb begin
      alu_lo  = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_lo = sum[WIDTH-1:0];
            alu_c  = sum[WIDTH];
            alu_v  = (opa[WIDTH-1] == mplier[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
         end
         OP_SUB: begin
            alu_lo = diff[WIDTH-1:0];
            alu_c  = diff[WIDTH];
            alu_v  = (opa[WIDTH-1] != mplier[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
         end
         OP_AND:  alu_lo = opa & mplier;
         OP_XOR:  alu_lo = opa ^ mplier;
         OP_OR:   alu_lo = opa | mplier;
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         result_hi <= '0;
         result_lo <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MUL: begin
               if (cnt == CNT_W'(WIDTH)) begin
                  result_hi <= acc[2*WIDTH-1:WIDTH];
                  result_lo <= acc[WIDTH-1:0];
                  carry     <= 1'b0;
                  overflow  <= 1'b0;
                  err       <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
               end
            end
            EXEC: begin
               result_hi <= '0;
               result_lo <= alu_lo;
               carry     <= alu_c;
               overflow  <= alu_v;
               err       <= alu_err;
               done      <= 1'b1;
               state     <= DONE;
            end
            default: begin
               if (start) begin
                  op_q   <= op;
                  mcand  <= {{WIDTH{1'b0}}, a};
                  mplier <= b;
                  acc    <= '0;
                  cnt    <= '0;
                  if (op == OP_MUL) begin
                     busy  <= 1'b1;
                     state <= MUL;
                  end else begin
                     state <= EXEC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_mul.sv
// Scoreboard bench for alu_seq_mul at WIDTH=8 and WIDTH=16: directed cases
// plus randomized commands checked against an arithmetic reference model.
module tb_alu_seq_mul;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        c;
      logic        v;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       start8, c8, v8, e8, busy8, done8;
   logic [2:0] op8;
   logic [7:0] a8, b8, hi8, lo8;

   logic        start16, c16, v16, e16, busy16, done16;
   logic [2:0]  op16;
   logic [15:0] a16, b16, hi16, lo16;

   alu_seq_mul #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .result_hi(hi8), .result_lo(lo8), .carry(c8), .overflow(v8), .err(e8),
      .busy(busy8), .done(done8));

   alu_seq_mul #(.WIDTH(16), .CNT_W(5)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
      .result_hi(hi16), .result_lo(lo16), .carry(c16), .overflow(v16), .err(e16),
      .busy(busy16), .done(done16));

   int   checks = 0;
   int   passed = 0;
   exp_t q8[$];
   exp_t q16[$];

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   // Reference: plain integer arithmetic, signed overflow judged by range.
   function automatic exp_t model(input int w, input logic [2:0] o, input longint a, input longint b);
      exp_t   x;
      longint m, h, r, sa, sb, sr;
      x  = '0;
      m  = (longint'(1) << w) - 1;
      h  = longint'(1) << (w - 1);
      sa = (a >= h) ? a - 2 * h : a;
      sb = (b >= h) ? b - 2 * h : b;
      case (o)
         3'b000: begin
            r = a + b; x.lo = 16'(r & m); x.c = (r > m);
            sr = sa + sb; x.v = (sr >= h) || (sr < -h);
         end
         3'b100: begin
            r = a - b; x.lo = 16'(r & m); x.c = (a < b);
            sr = sa - sb; x.v = (sr >= h) || (sr < -h);
         end
         3'b001: x.lo = 16'(a & b);
         3'b010: x.lo = 16'(a ^ b);
         3'b101: x.lo = 16'(a | b);
         3'b011: begin
            r = a * b; x.lo = 16'(r & m); x.hi = 16'(r >> w);
         end
         default: x.e = 1'b1;
      endcase
      return x;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done8) begin
         exp_t got, want;
         got = {8'h00, hi8, 8'h00, lo8, c8, v8, e8};
         if (q8.size() == 0) check("done8_unexpected", 1'b0, "done pulsed with no command pending");
         else begin
            want = q8.pop_front();
            check("res8", got == want && !busy8,
               $sformatf("got hi=%h lo=%h c=%b v=%b e=%b busy=%b, want hi=%h lo=%h c=%b v=%b e=%b busy=0",
                         got.hi, got.lo, got.c, got.v, got.e, busy8, want.hi, want.lo, want.c, want.v, want.e));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done16) begin
         exp_t got, want;
         got = {hi16, lo16, c16, v16, e16};
         if (q16.size() == 0) check("done16_unexpected", 1'b0, "done pulsed with no command pending");
         else begin
            want = q16.pop_front();
            check("res16", got == want && !busy16,
               $sformatf("got hi=%h lo=%h c=%b v=%b e=%b busy=%b, want hi=%h lo=%h c=%b v=%b e=%b busy=0",
                         got.hi, got.lo, got.c, got.v, got.e, busy16, want.hi, want.lo, want.c, want.v, want.e));
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that raised done.
   task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input int junk_at, input int abort_at, input bit has_want, input exp_t want);
      int lat;
      bit seen;
      int nd;
      lat  = (o == 3'b011) ? 9 : 1;
      seen = 1'b0;
      if (abort_at == 0) q8.push_back(has_want ? want : model(8, o, x, y));
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      for (int n = 1; n <= lat + 8 && !seen; n++) begin
         @(posedge clk); #1;
         start8 = 1'b0;
         if (done8) begin
            seen = 1'b1;
            check("lat8", n == lat, $sformatf("done after %0d cycles, required %0d", n, lat));
         end else if (n == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_clear", {hi8, lo8, c8, v8, e8, busy8, done8} == '0,
                  $sformatf("outputs hi=%h lo=%h c=%b v=%b e=%b busy=%b done=%b, required all 0",
                            hi8, lo8, c8, v8, e8, busy8, done8));
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            nd = 0;
            repeat (12) begin
               @(posedge clk); #1;
               if (done8) nd++;
            end
            check("abort_no_done", nd == 0, $sformatf("done pulses after abort %0d, required 0", nd));
            return;
         end else if (n == junk_at) begin
            check("busy_mid_mul", busy8 == 1'b1, $sformatf("busy=%b, required 1", busy8));
            start8 = 1'b1; op8 = 3'b000; a8 = 8'd1; b8 = 8'd1;
         end
      end
      if (!seen) check("timeout8", 1'b0, $sformatf("no done within %0d cycles", lat + 8));
   endtask

   task automatic issue16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      int lat;
      bit seen;
      lat  = (o == 3'b011) ? 17 : 1;
      seen = 1'b0;
      q16.push_back(model(16, o, x, y));
      start16 = 1'b1; op16 = o; a16 = x; b16 = y;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      for (int n = 1; n <= lat + 8 && !seen; n++) begin
         @(posedge clk); #1;
         if (done16) begin
            seen = 1'b1;
            check("lat16", n == lat, $sformatf("done after %0d cycles, required %0d", n, lat));
         end
      end
      if (!seen) check("timeout16", 1'b0, $sformatf("no done within %0d cycles", lat + 8));
   endtask

   task automatic gap();
      if ($urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      #2;
      check("reset8", {hi8, lo8, c8, v8, e8, busy8, done8} == '0,
            $sformatf("hi=%h lo=%h c=%b v=%b e=%b busy=%b done=%b, required all 0", hi8, lo8, c8, v8, e8, busy8, done8));
      check("reset16", {hi16, lo16, c16, v16, e16, busy16, done16} == '0,
            $sformatf("hi=%h lo=%h c=%b v=%b e=%b busy=%b done=%b, required all 0", hi16, lo16, c16, v16, e16, busy16, done16));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      issue8(3'b000, 8'd200, 8'd100, 0, 0, 1'b1, {16'h0, 16'h2C, 1'b1, 1'b0, 1'b0});
      issue8(3'b000, 8'd100, 8'd50,  0, 0, 1'b1, {16'h0, 16'h96, 1'b0, 1'b1, 1'b0});
      issue8(3'b100, 8'd5,   8'd7,   0, 0, 1'b1, {16'h0, 16'hFE, 1'b1, 1'b0, 1'b0});
      issue8(3'b100, 8'h80,  8'h01,  0, 0, 1'b1, {16'h0, 16'h7F, 1'b0, 1'b1, 1'b0});
      issue8(3'b000, 8'h7F,  8'h01,  0, 0, 1'b1, {16'h0, 16'h80, 1'b0, 1'b1, 1'b0});
      issue8(3'b011, 8'd255, 8'd255, 4, 0, 1'b1, {16'hFE, 16'h01, 1'b0, 1'b0, 1'b0});
      issue8(3'b011, 8'd13,  8'd11,  0, 5, 1'b0, '0);
      issue8(3'b001, 8'hF0,  8'h3C,  0, 0, 1'b1, {16'h0, 16'h30, 1'b0, 1'b0, 1'b0});
      issue8(3'b110, 8'd1,   8'd1,   0, 0, 1'b1, {16'h0, 16'h00, 1'b0, 1'b0, 1'b1});
      issue8(3'b010, 8'hAA,  8'hFF,  0, 0, 1'b1, {16'h0, 16'h55, 1'b0, 1'b0, 1'b0});
      repeat (3) @(posedge clk);
      #1;
      check("hold_idle", lo8 == 8'h55 && !e8 && !done8,
            $sformatf("lo=%h err=%b done=%b, required lo=55 err=0 done=0", lo8, e8, done8));

      for (int i = 0; i < 1000; i++) begin
         issue8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0, 0, 1'b0, '0);
         gap();
      end
      for (int i = 0; i < 1000; i++) begin
         issue16(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
         gap();
      end

      repeat (2) @(negedge clk);
      check("drain8", q8.size() == 0, $sformatf("%0d results outstanding, required 0", q8.size()));
      check("drain16", q16.size() == 0, $sformatf("%0d results outstanding, required 0", q16.size()));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
